psc_trigger_rx: RTL

Receive end of the power-supply-controller trigger link. Deserializes the single-wire frames driven onto the link by the PSC trigger transmitter and regenerates a local trigger pulse when the trigger code is received. Sits at the power-supply side, after the fibre/line receiver. Also exposes every received byte plus a framing-error flag for diagnostics.

---
 rtl/psc_trigger_rx.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/psc_trigger_rx.sv
// psc_trigger_rx: receive end of the PSC trigger link.
// Deserializes start/8N/stop frames from a single idle-high wire, strobes every good byte,
// flags frames whose stop bit is low, and stretches a local trigger pulse whenever the
// received byte equals TRIGGER_CODE.
module psc_trigger_rx #(
    parameter int unsigned CLKS_PER_BIT = 100,
    parameter logic [7:0]  TRIGGER_CODE = 8'hA5,
    parameter int unsigned TRIG_WIDTH   = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       psc_input,
    output logic       trigger_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned TrigW = $clog2(TRIG_WIDTH + 1);

    localparam logic [CntW-1:0]  BitLast     = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]  HalfLast    = CntW'(CLKS_PER_BIT / 2 - 1);
    // Cycles the synchronizer needs before rx_s reflects the real line after reset.
    localparam logic [CntW-1:0]  BreakSettle = CntW'(2);
    localparam logic [TrigW-1:0] TrigLoad    = TrigW'(TRIG_WIDTH);

    typedef enum logic [2:0] {
        StBreak,
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic              sync1_q;
    logic              rx_s;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [TrigW-1:0]  trig_cnt_q;
    logic              stop_done;
    logic              byte_ok;
    logic              byte_bad;

    // Two-flop synchronizer for the asynchronous line; resets to the idle-high level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_q <= psc_input;
            rx_s    <= sync1_q;
        end
    end

    // FSM state register; BREAK out of reset so a stuck-low line is never a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StBreak;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and bit-timing logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        unique case (state_q)
            StBreak: begin
                // The synchronizer resets high, so hold off until it carries the real line.
                if (cnt_q != BreakSettle) begin
                    cnt_d = cnt_q + CntW'(1);
                end else if (rx_s) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // Line back high at mid start bit means it was a glitch.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    // Leave at mid stop bit so a start bit right behind it is caught.
                    state_d = rx_s ? StIdle : StBreak;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StBreak;
                cnt_d   = '0;
            end
        endcase
    end

    // Decoded outputs of the FSM.
    always_comb begin
        busy      = (state_q != StIdle);
        stop_done = (state_q == StStop) && (cnt_q == BitLast);
        byte_ok   = stop_done && rx_s;
        byte_bad  = stop_done && !rx_s;
    end

    // Bit-timing counters, shift register and byte/error strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_valid    <= byte_ok;
            frame_error <= byte_bad;
            if (byte_ok) begin
                rx_data <= shift_q;
            end
        end
    end

    // Trigger stretcher; a new match reloads the counter so the pulse extends.
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_cnt_q  <= '0;
            trigger_out <= 1'b0;
        end else if (byte_ok && (shift_q == TRIGGER_CODE)) begin
            trig_cnt_q  <= TrigLoad;
            trigger_out <= 1'b1;
        end else if (trig_cnt_q != '0) begin
            trig_cnt_q <= trig_cnt_q - TrigW'(1);
            if (trig_cnt_q == TrigW'(1)) begin
                trigger_out <= 1'b0;
            end
        end
    end

endmodule
